// File: rtl/ctrl_decode_stage.sv
// Registered RV32I(+M) decode stage: decodes the IF/ID instruction into the control bundle
// and holds it in an ID/EX register behind a valid/ready handshake with load-use stalling.
module ctrl_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit EN_MEXT = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             ALUSrc,
  output logic [5:0]       EXTOp,
  output logic [4:0]       ALUOp,
  output logic [2:0]       NPCOp,
  output logic [1:0]       WDSel,
  output logic [2:0]       DMType,
  output logic             out_muldiv,
  output logic [2:0]       out_mdop,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_BNE   = 5'b00101;
  localparam logic [4:0] ALU_BLT   = 5'b00110;
  localparam logic [4:0] ALU_BGE   = 5'b00111;
  localparam logic [4:0] ALU_BLTU  = 5'b01000;
  localparam logic [4:0] ALU_BGEU  = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_XOR   = 5'b01100;
  localparam logic [4:0] ALU_OR    = 5'b01101;
  localparam logic [4:0] ALU_AND   = 5'b01110;
  localparam logic [4:0] ALU_SLL   = 5'b01111;
  localparam logic [4:0] ALU_SRL   = 5'b10000;
  localparam logic [4:0] ALU_SRA   = 5'b10001;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];

  logic       dec_regwrite, dec_memwrite, dec_alusrc, dec_muldiv, dec_illegal;
  logic [5:0] dec_extop;
  logic [4:0] dec_aluop;
  logic [2:0] dec_npcop, dec_dmtype;
  logic [1:0] dec_wdsel;

  always_comb begin
    dec_regwrite = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_extop    = '0;
    dec_aluop    = ALU_NOP;
    dec_npcop    = NPC_PLUS4;
    dec_wdsel    = WD_ALU;
    dec_dmtype   = DM_W;
    dec_muldiv   = 1'b0;
    dec_illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        dec_regwrite = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_aluop = ALU_ADD;
            3'b001:  dec_aluop = ALU_SLL;
            3'b010:  dec_aluop = ALU_SLT;
            3'b011:  dec_aluop = ALU_SLTU;
            3'b100:  dec_aluop = ALU_XOR;
            3'b101:  dec_aluop = ALU_SRL;
            3'b110:  dec_aluop = ALU_OR;
            default: dec_aluop = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_aluop = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_aluop = ALU_SRA;
        end else if (funct7 == 7'b0000001 && EN_MEXT) begin
          dec_muldiv = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_I: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_extop    = EXT_I;
        case (funct3)
          3'b000: dec_aluop = ALU_ADD;
          3'b010: dec_aluop = ALU_SLT;
          3'b011: dec_aluop = ALU_SLTU;
          3'b100: dec_aluop = ALU_XOR;
          3'b110: dec_aluop = ALU_OR;
          3'b111: dec_aluop = ALU_AND;
          3'b001: begin
            dec_extop   = EXT_SHAMT;
            dec_aluop   = ALU_SLL;
            dec_illegal = (funct7 != 7'b0000000);
          end
          default: begin
            dec_extop = EXT_SHAMT;
            if (funct7 == 7'b0000000)      dec_aluop = ALU_SRL;
            else if (funct7 == 7'b0100000) dec_aluop = ALU_SRA;
            else                           dec_illegal = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_extop    = EXT_I;
        dec_aluop    = ALU_ADD;
        dec_wdsel    = WD_MEM;
        case (funct3)
          3'b000:  dec_dmtype = DM_B;
          3'b001:  dec_dmtype = DM_H;
          3'b010:  dec_dmtype = DM_W;
          3'b100:  dec_dmtype = DM_BU;
          3'b101:  dec_dmtype = DM_HU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_extop    = EXT_S;
        dec_aluop    = ALU_ADD;
        case (funct3)
          3'b000:  dec_dmtype = DM_B;
          3'b001:  dec_dmtype = DM_H;
          3'b010:  dec_dmtype = DM_W;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_BR: begin
        dec_extop = EXT_B;
        dec_npcop = NPC_BRANCH;
        case (funct3)
          3'b000:  dec_aluop = ALU_SUB;
          3'b001:  dec_aluop = ALU_BNE;
          3'b100:  dec_aluop = ALU_BLT;
          3'b101:  dec_aluop = ALU_BGE;
          3'b110:  dec_aluop = ALU_BLTU;
          3'b111:  dec_aluop = ALU_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec_regwrite = 1'b1;
        dec_extop    = EXT_J;
        dec_npcop    = NPC_JUMP;
        dec_wdsel    = WD_PC;
      end
      OP_JALR: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_extop    = EXT_I;
        dec_aluop    = ALU_ADD;
        dec_npcop    = NPC_JALR;
        dec_wdsel    = WD_PC;
        dec_illegal  = (funct3 != 3'b000);
      end
      OP_LUI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_extop    = EXT_U;
        dec_aluop    = ALU_LUI;
      end
      OP_AUIPC: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_extop    = EXT_U;
        dec_aluop    = ALU_AUIPC;
      end
      default: dec_illegal = 1'b1;
    endcase
    // An illegal instruction travels down as an inert bundle tagged out_illegal.
    if (dec_illegal) begin
      dec_regwrite = 1'b0;
      dec_memwrite = 1'b0;
      dec_alusrc   = 1'b0;
      dec_extop    = '0;
      dec_aluop    = ALU_NOP;
      dec_npcop    = NPC_PLUS4;
      dec_wdsel    = WD_ALU;
      dec_dmtype   = DM_W;
      dec_muldiv   = 1'b0;
    end
    if (rd == 5'd0) dec_regwrite = 1'b0;
  end

  logic             valid_q, valid_d, regwrite_q, regwrite_d, memwrite_q, memwrite_d;
  logic             alusrc_q, alusrc_d, muldiv_q, muldiv_d, illegal_q, illegal_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, aluop_q, aluop_d;
  logic [5:0]       extop_q, extop_d;
  logic [2:0]       npcop_q, npcop_d, dmtype_q, dmtype_d, mdop_q, mdop_d;
  logic [1:0]       wdsel_q, wdsel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic use1, use2, hz, adv;
  assign use1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign use2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BR);
  assign hz   = valid_q && (wdsel_q == WD_MEM) && (rd_q != 5'd0) && in_valid &&
                ((use1 && rs1 == rd_q) || (use2 && rs2 == rd_q));
  assign adv      = ex_ready | ~valid_q;
  assign in_ready = adv & (~hz | flush);

  always_comb begin
    valid_d = valid_q; regwrite_d = regwrite_q; memwrite_d = memwrite_q;
    alusrc_d = alusrc_q; muldiv_d = muldiv_q; illegal_d = illegal_q;
    pc_d = pc_q; rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q; aluop_d = aluop_q;
    extop_d = extop_q; npcop_d = npcop_q; dmtype_d = dmtype_q; mdop_d = mdop_q;
    wdsel_d = wdsel_q; cnt_d = cnt_q;
    if (adv) begin
      if (flush || hz || !in_valid) begin
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        npcop_d    = NPC_PLUS4;
        if (!flush && hz) cnt_d = sat_inc(cnt_q);
      end else begin
        valid_d    = 1'b1;
        pc_d       = in_pc;
        rs1_d      = rs1;
        rs2_d      = rs2;
        rd_d       = rd;
        regwrite_d = dec_regwrite;
        memwrite_d = dec_memwrite;
        alusrc_d   = dec_alusrc;
        extop_d    = dec_extop;
        aluop_d    = dec_aluop;
        npcop_d    = dec_npcop;
        wdsel_d    = dec_wdsel;
        dmtype_d   = dec_dmtype;
        muldiv_d   = dec_muldiv;
        mdop_d     = dec_muldiv ? funct3 : 3'b000;
        illegal_d  = dec_illegal;
      end
    end
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0; regwrite_q <= 1'b0; memwrite_q <= 1'b0;
      alusrc_q <= 1'b0; muldiv_q <= 1'b0; illegal_q <= 1'b0;
      pc_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0; aluop_q <= '0;
      extop_q <= '0; npcop_q <= '0; dmtype_q <= '0; mdop_q <= '0;
      wdsel_q <= '0; cnt_q <= '0;
    end else begin
      valid_q <= valid_d; regwrite_q <= regwrite_d; memwrite_q <= memwrite_d;
      alusrc_q <= alusrc_d; muldiv_q <= muldiv_d; illegal_q <= illegal_d;
      pc_q <= pc_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d; aluop_q <= aluop_d;
      extop_q <= extop_d; npcop_q <= npcop_d; dmtype_q <= dmtype_d; mdop_q <= mdop_d;
      wdsel_q <= wdsel_d; cnt_q <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd      = rd_q;
  assign RegWrite    = regwrite_q;
  assign MemWrite    = memwrite_q;
  assign ALUSrc      = alusrc_q;
  assign EXTOp       = extop_q;
  assign ALUOp       = aluop_q;
  assign NPCOp       = npcop_q;
  assign WDSel       = wdsel_q;
  assign DMType      = dmtype_q;
  assign out_muldiv  = muldiv_q;
  assign out_mdop    = mdop_q;
  assign out_illegal = illegal_q;
  assign stall_cnt   = cnt_q;

endmodule
